// File: rtl/sdrc_wr_buf_pkg.sv
// Controller-wide constants and default widths for the SDRC write path.
package sdrc_wr_buf_pkg;

  localparam int unsigned SDRC_APP_DW    = 32;
  localparam int unsigned SDRC_APP_BW    = 4;
  localparam int unsigned SDRC_BUF_DEPTH = 8;
  localparam int unsigned SDRC_BUF_AW    = 3;

endpackage

// File: rtl/sdrc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered level counter.
// The caller qualifies push/pop; storage is not reset.
module sdrc_sync_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage write; intentionally without reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH (power of two); level tracks occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/sdrc_wr_buf.sv
// Application write buffer: FWFT FIFO plus empty masking, burst threshold,
// burst-done pulse and sticky underrun detection.
module sdrc_wr_buf
  import sdrc_wr_buf_pkg::*;
#(
  parameter int unsigned APP_DW    = SDRC_APP_DW,
  parameter int unsigned APP_BW    = SDRC_APP_BW,
  parameter int unsigned BUF_DEPTH = SDRC_BUF_DEPTH,
  parameter int unsigned BUF_AW    = SDRC_BUF_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              usr_wr_vld,
  input  logic [APP_DW-1:0] usr_wr_data,
  input  logic [APP_BW-1:0] usr_wr_en_n,
  output logic              usr_wr_rdy,
  output logic [APP_DW-1:0] app_wr_data,
  output logic [APP_BW-1:0] app_wr_en_n,
  input  logic              app_wr_next,
  input  logic              app_last_wr,
  input  logic [BUF_AW:0]   cfg_burst_len,
  output logic              burst_ok,
  output logic [BUF_AW:0]   buf_level,
  output logic              buf_empty,
  output logic              wr_burst_done,
  output logic              wr_underrun,
  input  logic              err_clr
);

  localparam logic [BUF_AW:0] FULL_LVL = (BUF_AW + 1)'(BUF_DEPTH);

  logic                     push;
  logic                     pop;
  logic [APP_BW+APP_DW-1:0] head;

  assign buf_empty  = (buf_level == '0);
  assign usr_wr_rdy = (buf_level != FULL_LVL);
  assign push       = usr_wr_vld && usr_wr_rdy;
  assign pop        = app_wr_next && !buf_empty;

  sdrc_sync_fifo #(
    .WIDTH (APP_BW + APP_DW),
    .DEPTH (BUF_DEPTH),
    .AW    (BUF_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({usr_wr_en_n, usr_wr_data}),
    .pop     (pop),
    .rdata   (head),
    .level   (buf_level)
  );

  // Mask the head while empty so stale storage never writes a byte.
  always_comb begin
    app_wr_data = '0;
    app_wr_en_n = '1;
    if (!buf_empty) begin
      app_wr_data = head[APP_DW-1:0];
      app_wr_en_n = head[APP_BW+APP_DW-1:APP_DW];
    end
  end

  // Thresholds beyond the depth can only be met by a full buffer.
  assign burst_ok = (cfg_burst_len > FULL_LVL) ? (buf_level == FULL_LVL)
                                               : (buf_level >= cfg_burst_len);

  // Burst-done pulse and sticky underrun; a new underrun beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_burst_done <= 1'b0;
      wr_underrun   <= 1'b0;
    end else begin
      wr_burst_done <= app_last_wr && pop;
      if (app_wr_next && buf_empty) wr_underrun <= 1'b1;
      else if (err_clr)             wr_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdrc_wr_buf.sv
// Directed-vector bench for sdrc_wr_buf with hand-computed expectations.
module tb_sdrc_wr_buf;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        usr_wr_vld;
  logic [31:0] usr_wr_data;
  logic [3:0]  usr_wr_en_n;
  logic        usr_wr_rdy;
  logic [31:0] app_wr_data;
  logic [3:0]  app_wr_en_n;
  logic        app_wr_next;
  logic        app_last_wr;
  logic [3:0]  cfg_burst_len;
  logic        burst_ok;
  logic [3:0]  buf_level;
  logic        buf_empty;
  logic        wr_burst_done;
  logic        wr_underrun;
  logic        err_clr;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  sdrc_wr_buf #(
    .APP_DW    (32),
    .APP_BW    (4),
    .BUF_DEPTH (8),
    .BUF_AW    (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .usr_wr_vld    (usr_wr_vld),
    .usr_wr_data   (usr_wr_data),
    .usr_wr_en_n   (usr_wr_en_n),
    .usr_wr_rdy    (usr_wr_rdy),
    .app_wr_data   (app_wr_data),
    .app_wr_en_n   (app_wr_en_n),
    .app_wr_next   (app_wr_next),
    .app_last_wr   (app_last_wr),
    .cfg_burst_len (cfg_burst_len),
    .burst_ok      (burst_ok),
    .buf_level     (buf_level),
    .buf_empty     (buf_empty),
    .wr_burst_done (wr_burst_done),
    .wr_underrun   (wr_underrun),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    usr_wr_vld  = 1'b0;
    app_wr_next = 1'b0;
    app_last_wr = 1'b0;
    err_clr     = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    usr_wr_data   = '0;
    usr_wr_en_n   = '0;
    cfg_burst_len = 4'd4;
    idle();
    tick();
    tick();

    // Reset state
    check("rst_level", 64'(buf_level), 64'd0);
    check("rst_empty", 64'(buf_empty), 64'd1);
    check("rst_rdy",   64'(usr_wr_rdy), 64'd1);
    check("rst_bok",   64'(burst_ok), 64'd0);
    check("rst_data",  64'(app_wr_data), 64'd0);
    check("rst_en_n",  64'(app_wr_en_n), 64'hF);
    check("rst_unr",   64'(wr_underrun), 64'd0);
    check("rst_done",  64'(wr_burst_done), 64'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_level", 64'(buf_level), 64'd0);

    // Fill to full, then drain in order
    for (int i = 0; i < 8; i++) begin
      usr_wr_vld  = 1'b1;
      usr_wr_data = 32'h11111111 * (i + 1);
      usr_wr_en_n = 4'h0;
      tick();
    end
    check("full_rdy",   64'(usr_wr_rdy), 64'd0);
    check("full_level", 64'(buf_level), 64'd8);
    usr_wr_data = 32'h99999999;
    tick();
    check("full_hold_level", 64'(buf_level), 64'd8);
    usr_wr_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("drain_data", 64'(app_wr_data), 64'(32'h11111111 * (i + 1)));
      app_wr_next = 1'b1;
      tick();
    end
    app_wr_next = 1'b0;
    check("drain_empty", 64'(buf_empty), 64'd1);
    check("drain_data0", 64'(app_wr_data), 64'd0);
    check("drain_unr",   64'(wr_underrun), 64'd0);

    // Single push latency and empty masking
    check("pre_data", 64'(app_wr_data), 64'd0);
    check("pre_en_n", 64'(app_wr_en_n), 64'hF);
    usr_wr_vld  = 1'b1;
    usr_wr_data = 32'hA5A5A5A5;
    usr_wr_en_n = 4'hC;
    tick();
    usr_wr_vld = 1'b0;
    check("one_data",  64'(app_wr_data), 64'hA5A5A5A5);
    check("one_en_n",  64'(app_wr_en_n), 64'hC);
    check("one_level", 64'(buf_level), 64'd1);
    app_wr_next = 1'b1;
    tick();
    app_wr_next = 1'b0;
    check("one_pop_level", 64'(buf_level), 64'd0);

    // Steady-state push+pop at level 3 across pointer wrap
    usr_wr_en_n = 4'h0;
    for (int i = 1; i <= 3; i++) begin
      usr_wr_vld  = 1'b1;
      usr_wr_data = 32'(i);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      usr_wr_vld  = 1'b1;
      usr_wr_data = 32'(4 + k);
      app_wr_next = 1'b1;
      check("pp_head", 64'(app_wr_data), 64'(k + 1));
      tick();
      check("pp_level", 64'(buf_level), 64'd3);
    end
    idle();
    for (int i = 11; i <= 13; i++) begin
      check("pp_tail", 64'(app_wr_data), 64'(i));
      app_wr_next = 1'b1;
      tick();
    end
    idle();
    check("pp_empty", 64'(buf_empty), 64'd1);

    // Burst threshold and burst-done pulse
    cfg_burst_len = 4'd0;
    #1 check("bok_len0", 64'(burst_ok), 64'd1);
    cfg_burst_len = 4'd9;
    #1 check("bok_len9_empty", 64'(burst_ok), 64'd0);
    cfg_burst_len = 4'd4;
    app_last_wr   = 1'b1;
    tick();
    check("last_no_pop", 64'(wr_burst_done), 64'd0);
    app_last_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      usr_wr_vld  = 1'b1;
      usr_wr_data = 32'h100 + 32'(i);
      tick();
    end
    check("bok_3", 64'(burst_ok), 64'd0);
    usr_wr_data = 32'h103;
    tick();
    usr_wr_vld = 1'b0;
    check("bok_4", 64'(burst_ok), 64'd1);
    for (int i = 0; i < 4; i++) begin
      app_wr_next = 1'b1;
      app_last_wr = (i == 3);
      check("burst_data", 64'(app_wr_data), 64'(32'h100 + 32'(i)));
      tick();
      check("burst_done", 64'(wr_burst_done), 64'(i == 3));
    end
    idle();
    tick();
    check("burst_done_end", 64'(wr_burst_done), 64'd0);

    // Underrun set, hold, clear, and set-wins
    app_wr_next = 1'b1;
    tick();
    app_wr_next = 1'b0;
    check("unr_set",   64'(wr_underrun), 64'd1);
    check("unr_level", 64'(buf_level), 64'd0);
    tick();
    check("unr_hold", 64'(wr_underrun), 64'd1);
    err_clr = 1'b1;
    tick();
    check("unr_clr", 64'(wr_underrun), 64'd0);
    app_wr_next = 1'b1;
    tick();
    check("unr_set_wins", 64'(wr_underrun), 64'd1);
    idle();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("unr_clr2", 64'(wr_underrun), 64'd0);
    usr_wr_vld  = 1'b1;
    usr_wr_data = 32'h5A5A5A5A;
    app_wr_next = 1'b1;
    tick();
    idle();
    check("unr_push_level", 64'(buf_level), 64'd1);
    check("unr_push_flag",  64'(wr_underrun), 64'd1);
    check("unr_push_data",  64'(app_wr_data), 64'h5A5A5A5A);

    // Asynchronous reset with level 5 and underrun pending
    for (int i = 0; i < 4; i++) begin
      usr_wr_vld  = 1'b1;
      usr_wr_data = 32'h200 + 32'(i);
      tick();
    end
    usr_wr_vld = 1'b0;
    check("pre_arst_level", 64'(buf_level), 64'd5);
    #2 reset_n = 1'b0;
    #1;
    check("arst_level", 64'(buf_level), 64'd0);
    check("arst_rdy",   64'(usr_wr_rdy), 64'd1);
    check("arst_en_n",  64'(app_wr_en_n), 64'hF);
    check("arst_unr",   64'(wr_underrun), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("arst_rel_level", 64'(buf_level), 64'd0);
    check("arst_rel_done",  64'(wr_burst_done), 64'd0);
    check("arst_rel_data",  64'(app_wr_data), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
